// File: rtl/simd_issue_sched.sv
// Round-robin issue scheduler sharing one fixed-latency SIMD unit between NREQ requesters, with credit-checked result FIFO.
// Define SIMD_SCHED_PRIO0_EN to give requester 0 strict priority (round-robin then covers requesters 1..NREQ-1).
module simd_issue_sched #(
   parameter int NREQ  = 2,
   parameter int SRCW  = 1,
   parameter int TAGW  = 9,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*13-1:0]   req_op,
   input  logic [NREQ*68-1:0]   req_A,
   input  logic [NREQ*68-1:0]   req_B,
   input  logic [NREQ*TAGW-1:0] req_tag,
   output logic                 simd_en,
   output logic [12:0]          simd_op,
   output logic [67:0]          simd_A,
   output logic [67:0]          simd_B,
   input  logic [67:0]          simd_res,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [67:0]          res_data,
   output logic [TAGW-1:0]      res_tag,
   output logic [SRCW-1:0]      res_src
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 2;

   logic [SRCW-1:0] rr_q, rr_d;
   logic            simd_en_q, simd_en_d;
   logic [12:0]     simd_op_q, simd_op_d;
   logic [67:0]     simd_A_q, simd_A_d, simd_B_q, simd_B_d;

   // Stage 0 coincides with simd_en; stage LAT is the cycle simd_res is valid.
   logic [LAT:0]    sh_vld_q, sh_vld_d;
   logic [TAGW-1:0] sh_tag_q [LAT+1];
   logic [TAGW-1:0] sh_tag_d [LAT+1];
   logic [SRCW-1:0] sh_src_q [LAT+1];
   logic [SRCW-1:0] sh_src_d [LAT+1];

   logic [67:0]     mem_data_q [DEPTH];
   logic [67:0]     mem_data_d [DEPTH];
   logic [TAGW-1:0] mem_tag_q  [DEPTH];
   logic [TAGW-1:0] mem_tag_d  [DEPTH];
   logic [SRCW-1:0] mem_src_q  [DEPTH];
   logic [SRCW-1:0] mem_src_d  [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d, inflight_q, inflight_d;

   logic            can_issue, gnt_vld, accept, push, pop;
   logic [SRCW-1:0] gnt_idx;
   logic [12:0]     sel_op;
   logic [67:0]     sel_A, sel_B;
   logic [TAGW-1:0] sel_tag;

   // Credit uses registered counts only, so a pop never reaches req_ready in the same cycle.
   assign can_issue = !rst && ((inflight_q + fifo_cnt_q) < CW'(DEPTH));
   assign accept    = can_issue && gnt_vld;

   always_comb begin
      int idx;
      logic [SRCW-1:0] cand;
      idx     = 0;
      cand    = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      rr_d    = rr_q;
`ifdef SIMD_SCHED_PRIO0_EN
      if (req_valid[0]) begin
         gnt_vld = 1'b1;
      end else begin
         for (int k = 0; k < NREQ-1; k++) begin
            idx  = 1 + ((int'(rr_q) + k) % (NREQ-1));
            cand = SRCW'(idx);
            if (!gnt_vld && req_valid[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      if (accept && gnt_idx != '0)
         rr_d = SRCW'(int'(gnt_idx) % (NREQ-1));
`else
      for (int k = 0; k < NREQ; k++) begin
         idx  = (int'(rr_q) + k) % NREQ;
         cand = SRCW'(idx);
         if (!gnt_vld && req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      if (accept)
         rr_d = SRCW'((int'(gnt_idx) + 1) % NREQ);
`endif
   end

   always_comb begin
      req_ready = '0;
      sel_op    = '0;
      sel_A     = '0;
      sel_B     = '0;
      sel_tag   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == SRCW'(i)) begin
            req_ready[i] = accept;
            sel_op       = req_op[i*13 +: 13];
            sel_A        = req_A[i*68 +: 68];
            sel_B        = req_B[i*68 +: 68];
            sel_tag      = req_tag[i*TAGW +: TAGW];
         end
      end
   end

   assign push = sh_vld_q[LAT];
   assign pop  = res_valid && res_ready;

   always_comb begin
      simd_en_d   = accept;
      simd_op_d   = accept ? sel_op : simd_op_q;
      simd_A_d    = accept ? sel_A  : simd_A_q;
      simd_B_d    = accept ? sel_B  : simd_B_q;
      sh_vld_d    = {sh_vld_q[LAT-1:0], accept};
      sh_tag_d    = sh_tag_q;
      sh_src_d    = sh_src_q;
      sh_tag_d[0] = sel_tag;
      sh_src_d[0] = gnt_idx;
      for (int k = 1; k <= LAT; k++) begin
         sh_tag_d[k] = sh_tag_q[k-1];
         sh_src_d[k] = sh_src_q[k-1];
      end

      mem_data_d = mem_data_q;
      mem_tag_d  = mem_tag_q;
      mem_src_d  = mem_src_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) begin
         mem_data_d[wr_ptr_q] = simd_res;
         mem_tag_d[wr_ptr_q]  = sh_tag_q[LAT];
         mem_src_d[wr_ptr_q]  = sh_src_q[LAT];
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + PW'(1);

      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop)
         fifo_cnt_d = fifo_cnt_q + CW'(1);
      else if (pop && !push)
         fifo_cnt_d = fifo_cnt_q - CW'(1);

      inflight_d = inflight_q;
      if (accept && !push)
         inflight_d = inflight_q + CW'(1);
      else if (push && !accept)
         inflight_d = inflight_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      simd_op_q  <= simd_op_d;
      simd_A_q   <= simd_A_d;
      simd_B_q   <= simd_B_d;
      sh_tag_q   <= sh_tag_d;
      sh_src_q   <= sh_src_d;
      mem_data_q <= mem_data_d;
      mem_tag_q  <= mem_tag_d;
      mem_src_q  <= mem_src_d;
      if (rst) begin
         rr_q       <= '0;
         simd_en_q  <= 1'b0;
         sh_vld_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         inflight_q <= '0;
      end else begin
         rr_q       <= rr_d;
         simd_en_q  <= simd_en_d;
         sh_vld_q   <= sh_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         inflight_q <= inflight_d;
         if (push)
            assert (fifo_cnt_q != CW'(DEPTH));
      end
   end

   assign simd_en   = simd_en_q;
   assign simd_op   = simd_op_q;
   assign simd_A    = simd_A_q;
   assign simd_B    = simd_B_q;
   assign res_valid = (fifo_cnt_q != '0);
   assign res_data  = mem_data_q[rd_ptr_q];
   assign res_tag   = mem_tag_q[rd_ptr_q];
   assign res_src   = mem_src_q[rd_ptr_q];
endmodule

// File: tb/tb_simd_issue_sched.sv
// Directed bench for simd_issue_sched with a behavioural LAT-cycle SIMD unit (add/sub) driving simd_res.
module tb_simd_issue_sched;
   localparam int NREQ  = 2;
   localparam int SRCW  = 1;
   localparam int TAGW  = 9;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam logic [12:0] OP_PADD = 13'h0001;
   localparam logic [12:0] OP_PSUB = 13'h0002;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req_valid, req_ready;
   logic [12:0]     op0, op1;
   logic [67:0]     a0, a1, b0, b1;
   logic [TAGW-1:0] tag0, tag1;
   logic            simd_en;
   logic [12:0]     simd_op;
   logic [67:0]     simd_A, simd_B, simd_res;
   logic            res_valid, res_ready;
   logic [67:0]     res_data;
   logic [TAGW-1:0] res_tag;
   logic [SRCW-1:0] res_src;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   simd_issue_sched #(.NREQ(NREQ), .SRCW(SRCW), .TAGW(TAGW), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op({op1, op0}), .req_A({a1, a0}), .req_B({b1, b0}), .req_tag({tag1, tag0}),
      .simd_en(simd_en), .simd_op(simd_op), .simd_A(simd_A), .simd_B(simd_B), .simd_res(simd_res),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_tag(res_tag), .res_src(res_src)
   );

   logic [67:0] pipe_q [LAT];
   always @(posedge clk) begin
      pipe_q[0] <= simd_en ? ((simd_op == OP_PADD) ? simd_A + simd_B : simd_A - simd_B) : 68'h0;
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
   end
   assign simd_res = pipe_q[LAT-1];

   task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] gnt_log [6];
      int  n_gnt, n_acc, seen;
      logic acc;

      rst = 1'b1; req_valid = '0; res_ready = 1'b0;
      op0 = OP_PADD; op1 = OP_PADD; a0 = '0; a1 = '0; b0 = '0; b1 = '0; tag0 = '0; tag1 = '0;

      // reset held 3 cycles with every requester valid
      req_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         chk_eq("rst_req_ready", req_ready, 2'b00);
         chk_eq("rst_simd_en", simd_en, 1'b0);
         chk_eq("rst_res_valid", res_valid, 1'b0);
      end
      rst = 1'b0; req_valid = '0; res_ready = 1'b1;
      step();

      // single op: accept t, simd_en t+1, res_valid t+4
      op0 = OP_PADD; a0 = 68'd5; b0 = 68'd3; tag0 = 9'h11; req_valid = 2'b01; #1;
      chk_eq("single_ready", req_ready, 2'b01);
      step(); req_valid = '0; #1;
      chk_eq("single_en", simd_en, 1'b1);
      chk_eq("single_op", simd_op, OP_PADD);
      chk_eq("single_A", simd_A, 68'd5);
      chk_eq("single_B", simd_B, 68'd3);
      step(); #1;
      chk_eq("single_en_off", simd_en, 1'b0);
      chk_eq("single_A_hold", simd_A, 68'd5);
      chk_eq("single_rv_t2", res_valid, 1'b0);
      step(); #1;
      chk_eq("single_rv_t3", res_valid, 1'b0);
      step(); #1;
      chk_eq("single_rv_t4", res_valid, 1'b1);
      chk_eq("single_data", res_data, 68'd8);
      chk_eq("single_tag", res_tag, 9'h11);
      chk_eq("single_src", res_src, 1'b0);
      step(); #1;
      chk_eq("single_rv_t5", res_valid, 1'b0);

      // round-robin with both requesters valid
      do_reset();
      res_ready = 1'b1;
      tag0 = 9'h20; tag1 = 9'h30; op1 = OP_PSUB; a1 = 68'd10; b1 = 68'd4;
      req_valid = 2'b11;
      n_gnt = 0;
      for (int c = 0; c < 40 && n_gnt < 6; c++) begin
         #1;
         if (req_ready != '0) begin
            gnt_log[n_gnt] = req_ready;
            n_gnt++;
         end
         step();
      end
      req_valid = '0;
      chk_eq("rr_grant_count", n_gnt, 6);
      for (int i = 0; i < n_gnt; i++)
         chk_eq($sformatf("rr_grant%0d", i), gnt_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      repeat (8) step();

      // backpressure: only DEPTH accepts while writeback stalls
      do_reset();
      res_ready = 1'b0; op0 = OP_PADD; b0 = 68'd1; tag0 = 9'h40; a0 = 68'h40;
      req_valid = 2'b01;
      n_acc = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         acc = req_ready[0];
         step();
         if (acc) begin
            n_acc++; tag0 = tag0 + 9'd1; a0 = a0 + 68'd1;
         end
      end
      #1;
      chk_eq("bp_accepts", n_acc, 4);
      chk_eq("bp_full_ready", req_ready, 2'b00);
      chk_eq("bp_full_rv", res_valid, 1'b1);
      res_ready = 1'b1; #1;
      chk_eq("bp_pop_no_credit", req_ready, 2'b00);
      chk_eq("bp_head0_tag", res_tag, 9'h40);
      chk_eq("bp_head0_data", res_data, 68'h41);
      step(); #1;
      chk_eq("bp_credit_back", req_ready, 2'b01);
      chk_eq("bp_head1_tag", res_tag, 9'h41);
      chk_eq("bp_head1_data", res_data, 68'h42);
      step(); req_valid = '0; #1;
      chk_eq("bp_head2_tag", res_tag, 9'h42);
      step(); #1;
      chk_eq("bp_head3_tag", res_tag, 9'h43);
      chk_eq("bp_head3_data", res_data, 68'h44);
      step(); #1;
      chk_eq("bp_drained", res_valid, 1'b0);
      step(); #1;
      chk_eq("bp_new_rv", res_valid, 1'b1);
      chk_eq("bp_new_tag", res_tag, 9'h44);
      chk_eq("bp_new_data", res_data, 68'h45);
      step();

      // push and pop together at 3 entries, write pointer wraps past index 3
      res_ready = 1'b0; op1 = OP_PADD; b1 = 68'd2; tag1 = 9'h50; a1 = 68'h50;
      req_valid = 2'b10;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk_eq($sformatf("pp_accept%0d", c), req_ready, 2'b10);
         step();
         tag1 = tag1 + 9'd1; a1 = a1 + 68'd1;
      end
      req_valid = '0;
      repeat (3) step();
      req_valid = 2'b10; #1;
      chk_eq("pp_accept3", req_ready, 2'b10);
      step(); req_valid = '0;
      step(); step(); #1;
      chk_eq("pp_full_head_tag", res_tag, 9'h50);
      res_ready = 1'b1;
      step(); #1;
      chk_eq("pp_head1_rv", res_valid, 1'b1);
      chk_eq("pp_head1_tag", res_tag, 9'h51);
      chk_eq("pp_head1_data", res_data, 68'h53);
      chk_eq("pp_head1_src", res_src, 1'b1);
      step(); #1;
      chk_eq("pp_head2_tag", res_tag, 9'h52);
      step(); #1;
      chk_eq("pp_head3_tag", res_tag, 9'h53);
      chk_eq("pp_head3_data", res_data, 68'h55);
      step(); #1;
      chk_eq("pp_empty", res_valid, 1'b0);

      // reset while two ops are in the shadow pipe
      res_ready = 1'b1; op0 = OP_PADD; a0 = 68'd1; b0 = 68'd1; tag0 = 9'h60;
      req_valid = 2'b01; #1;
      chk_eq("mid_acc0", req_ready, 2'b01);
      step(); #1;
      chk_eq("mid_acc1", req_ready, 2'b01);
      step();
      rst = 1'b1; #1;
      chk_eq("mid_rst_ready", req_ready, 2'b00);
      step();
      rst = 1'b0; req_valid = '0; #1;
      chk_eq("mid_rst_en", simd_en, 1'b0);
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (res_valid) seen++;
         step(); #1;
      end
      chk_eq("mid_rst_no_result", seen, 0);
      res_ready = 1'b0; req_valid = 2'b01;
      n_acc = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (req_ready[0]) n_acc++;
         step();
      end
      req_valid = '0;
      chk_eq("mid_rst_credits", n_acc, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
